// File: rtl/multi_unit_interrupt_controller.sv
// Round-robin sequencer ownership arbiter: an interrupt edge from the current owner
// saves its PC, parks it in reset, idles the bus for a drain window, then grants the next unit.
module multi_unit_interrupt_controller #(
  parameter int N_UNITS = 2,
  parameter int PC_W    = 32,
  parameter int OWNER_W = (N_UNITS > 2) ? $clog2(N_UNITS) : 1,
  parameter int DRAIN   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    interrupt_reset,
  input  logic                    seq_reset,
  input  logic                    pc_reset,
  input  logic [N_UNITS-1:0]      int_req,
  input  logic [N_UNITS*PC_W-1:0] unit_pc,
  output logic [N_UNITS-1:0]      seq_en,
  output logic [N_UNITS-1:0]      seq_reset_out,
  output logic [OWNER_W-1:0]      bus_owner,
  output logic [PC_W-1:0]         epc,
  output logic [N_UNITS-1:0]      int_ack,
  output logic                    busy,
  output logic [CNT_W-1:0]        switch_count,
  output logic                    err_spurious
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   bus_owner_q, bus_owner_d;
  logic [N_UNITS-1:0]   seq_en_q, seq_en_d;
  logic [N_UNITS-1:0]   rst_int_q, rst_int_d;
  logic [N_UNITS-1:0]   seq_reset_out_q, seq_reset_out_d;
  logic [PC_W-1:0]      epc_q, epc_d;
  logic [N_UNITS-1:0]   int_ack_q, int_ack_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     switch_count_q, switch_count_d;
  logic                 err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [N_UNITS-1:0]   req_q, req_d;

  logic [N_UNITS-1:0]   req_edge;
  logic [N_UNITS-1:0]   owner_mask;
  logic [N_UNITS-1:0]   tgt_mask;
  logic [OWNER_W-1:0]   tgt;
  logic [PC_W-1:0]      pc_sel;

  always_comb begin
    req_edge = int_req & ~req_q;
    tgt = (bus_owner_q == OWNER_W'(N_UNITS - 1)) ? '0 : bus_owner_q + OWNER_W'(1);
    owner_mask = '0;
    tgt_mask   = '0;
    pc_sel     = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      owner_mask[i] = (bus_owner_q == OWNER_W'(i));
      tgt_mask[i]   = (tgt == OWNER_W'(i));
      if (bus_owner_q == OWNER_W'(i)) pc_sel = unit_pc[i*PC_W +: PC_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    bus_owner_d    = bus_owner_q;
    seq_en_d       = seq_en_q;
    rst_int_d      = rst_int_q;
    int_ack_d      = '0;
    busy_d         = busy_q;
    switch_count_d = switch_count_q;
    cnt_d          = cnt_q;
    req_d          = int_req;
    // Any non-owner edge, or any edge during a handoff, is flagged and otherwise ignored.
    err_d = err_q | (|(req_edge & ~owner_mask)) | ((state_q == ST_DRAIN) && (|req_edge));
    epc_d = pc_reset ? '0 : epc_q;
    case (state_q)
      ST_RUN: begin
        if ((|(req_edge & owner_mask)) && !pc_reset) begin
          epc_d     = pc_sel;
          seq_en_d  = '0;
          rst_int_d = rst_int_q | owner_mask;
          cnt_d     = 8'(DRAIN);
          busy_d    = 1'b1;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          bus_owner_d    = tgt;
          seq_en_d       = tgt_mask;
          rst_int_d      = rst_int_q & ~tgt_mask;
          int_ack_d      = tgt_mask;
          switch_count_d = switch_count_q + CNT_W'(1);
          busy_d         = 1'b0;
          state_d        = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // External sequencer reset overlays the internal per-unit reset state.
    seq_reset_out_d = rst_int_d | {N_UNITS{seq_reset}};
  end

  always_ff @(posedge clk or posedge interrupt_reset) begin
    if (interrupt_reset) begin
      state_q         <= ST_RUN;
      bus_owner_q     <= '0;
      seq_en_q        <= N_UNITS'(1);
      rst_int_q       <= '0;
      seq_reset_out_q <= '0;
      epc_q           <= '0;
      int_ack_q       <= '0;
      busy_q          <= 1'b0;
      switch_count_q  <= '0;
      err_q           <= 1'b0;
      cnt_q           <= '0;
      req_q           <= '0;
    end else begin
      state_q         <= state_d;
      bus_owner_q     <= bus_owner_d;
      seq_en_q        <= seq_en_d;
      rst_int_q       <= rst_int_d;
      seq_reset_out_q <= seq_reset_out_d;
      epc_q           <= epc_d;
      int_ack_q       <= int_ack_d;
      busy_q          <= busy_d;
      switch_count_q  <= switch_count_d;
      err_q           <= err_d;
      cnt_q           <= cnt_d;
      req_q           <= req_d;
    end
  end

  assign seq_en        = seq_en_q;
  assign seq_reset_out = seq_reset_out_q;
  assign bus_owner     = bus_owner_q;
  assign epc           = epc_q;
  assign int_ack       = int_ack_q;
  assign busy          = busy_q;
  assign switch_count  = switch_count_q;
  assign err_spurious  = err_q;

endmodule

// File: tb/tb_multi_unit_interrupt_controller.sv
// Bench for multi_unit_interrupt_controller (N_UNITS=2, DRAIN=2): directed scenarios followed
// by random stimulus, all compared against a cycle-count based reference model.
module tb_multi_unit_interrupt_controller;

  localparam int N     = 2;
  localparam int PC_W  = 32;
  localparam int DRAIN = 2;
  localparam int CNT_W = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              interrupt_reset;
  logic              seq_reset;
  logic              pc_reset;
  logic [N-1:0]      int_req;
  logic [N*PC_W-1:0] unit_pc;
  logic [N-1:0]      seq_en;
  logic [N-1:0]      seq_reset_out;
  logic [0:0]        bus_owner;
  logic [PC_W-1:0]   epc;
  logic [N-1:0]      int_ack;
  logic              busy;
  logic [CNT_W-1:0]  switch_count;
  logic              err_spurious;

  multi_unit_interrupt_controller #(
    .N_UNITS(N), .PC_W(PC_W), .OWNER_W(1), .DRAIN(DRAIN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .interrupt_reset(interrupt_reset), .seq_reset(seq_reset), .pc_reset(pc_reset),
    .int_req(int_req), .unit_pc(unit_pc), .seq_en(seq_en), .seq_reset_out(seq_reset_out),
    .bus_owner(bus_owner), .epc(epc), .int_ack(int_ack), .busy(busy),
    .switch_count(switch_count), .err_spurious(err_spurious)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: handoff timed by absolute clock index, not by a down-counter
  int              m_cyc;
  int              m_owner;
  bit              m_busy;
  int              m_grant_cyc;
  logic [PC_W-1:0] m_epc;
  logic [N-1:0]    m_released;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_sro;
  logic [CNT_W-1:0] m_count;
  bit              m_err;
  logic [N-1:0]    m_prev;

  task automatic model_reset();
    m_cyc = 0; m_owner = 0; m_busy = 0; m_grant_cyc = -1; m_epc = '0;
    m_released = '0; m_ack = '0; m_sro = '0; m_count = '0; m_err = 0; m_prev = '0;
  endtask

  task automatic model_clock();
    logic [N-1:0] edges;
    logic [N-1:0] own;
    edges  = int_req & ~m_prev;
    m_prev = int_req;
    own    = N'(1) << m_owner;
    m_ack  = '0;
    if ((edges & ~own) != 0 || (m_busy && edges != 0)) m_err = 1;
    if (pc_reset) m_epc = '0;
    if (!m_busy) begin
      if (edges[m_owner] && !pc_reset) begin
        m_epc       = unit_pc[m_owner*PC_W +: PC_W];
        m_released  = m_released | own;
        m_busy      = 1;
        m_grant_cyc = m_cyc + 1 + DRAIN;
      end
    end else if (m_cyc == m_grant_cyc) begin
      m_owner    = (m_owner + 1) % N;
      m_released = m_released & ~(N'(1) << m_owner);
      m_ack      = N'(1) << m_owner;
      m_count    = m_count + 1'b1;
      m_busy     = 0;
    end
    m_sro = m_released | {N{seq_reset}};
    m_cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".seq_en"},        64'(seq_en),        64'(m_busy ? N'(0) : N'(1) << m_owner));
    chk({tag, ".seq_reset_out"}, 64'(seq_reset_out), 64'(m_sro));
    chk({tag, ".bus_owner"},     64'(bus_owner),     64'(m_owner));
    chk({tag, ".epc"},           64'(epc),           64'(m_epc));
    chk({tag, ".int_ack"},       64'(int_ack),       64'(m_ack));
    chk({tag, ".busy"},          64'(busy),          64'(m_busy));
    chk({tag, ".switch_count"},  64'(switch_count),  64'(m_count));
    chk({tag, ".err_spurious"},  64'(err_spurious),  64'(m_err));
  endtask

  // driver: one clock with current inputs, then compare 1 time unit after the edge
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_model(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".seq_en"},        64'(seq_en),        64'h1);
    chk({tag, ".bus_owner"},     64'(bus_owner),     64'h0);
    chk({tag, ".epc"},           64'(epc),           64'h0);
    chk({tag, ".seq_reset_out"}, 64'(seq_reset_out), 64'h0);
    chk({tag, ".busy"},          64'(busy),          64'h0);
    chk({tag, ".switch_count"},  64'(switch_count),  64'h0);
    chk({tag, ".err_spurious"},  64'(err_spurious),  64'h0);
    chk({tag, ".int_ack"},       64'(int_ack),       64'h0);
  endtask

  initial begin
    interrupt_reset = 1'b1; seq_reset = 1'b0; pc_reset = 1'b0;
    int_req = '0; unit_pc = {32'h0000_02A0, 32'h0000_0100};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    interrupt_reset = 1'b0;

    // owner 0 interrupts: disabled at k, unit 1 granted at k+3
    int_req = 2'b01;
    step("h0_k");
    chk("h0_k.epc", 64'(epc), 64'h100);
    chk("h0_k.seq_en", 64'(seq_en), 64'h0);
    chk("h0_k.seq_reset_out", 64'(seq_reset_out), 64'h1);
    chk("h0_k.busy", 64'(busy), 64'h1);
    step("h0_k1");
    step("h0_k2");
    chk("h0_k2.seq_en", 64'(seq_en), 64'h0);
    step("h0_k3");
    chk("h0_k3.bus_owner", 64'(bus_owner), 64'h1);
    chk("h0_k3.seq_en", 64'(seq_en), 64'h2);
    chk("h0_k3.int_ack", 64'(int_ack), 64'h2);
    chk("h0_k3.switch_count", 64'(switch_count), 64'h1);
    step("h0_k4");
    chk("h0_k4.int_ack", 64'(int_ack), 64'h0);

    // owner 1 interrupts, wraps back to unit 0
    int_req = 2'b10;
    step("h1_k");
    chk("h1_k.epc", 64'(epc), 64'h2A0);
    step("h1_k1");
    step("h1_k2");
    step("h1_k3");
    chk("h1_k3.bus_owner", 64'(bus_owner), 64'h0);
    chk("h1_k3.seq_en", 64'(seq_en), 64'h1);
    chk("h1_k3.seq_reset_out", 64'(seq_reset_out), 64'h2);
    chk("h1_k3.switch_count", 64'(switch_count), 64'h2);
    int_req = 2'b00;
    step("idle0");

    // non-owner edge
    int_req = 2'b10;
    step("spur");
    chk("spur.err", 64'(err_spurious), 64'h1);
    chk("spur.busy", 64'(busy), 64'h0);
    int_req = 2'b00;
    step("spur_hold");
    chk("spur_hold.err", 64'(err_spurious), 64'h1);

    // owner edge dropped while pc_reset is high
    pc_reset = 1'b1; int_req = 2'b01;
    step("pcr");
    chk("pcr.busy", 64'(busy), 64'h0);
    chk("pcr.epc", 64'(epc), 64'h0);
    chk("pcr.seq_en", 64'(seq_en), 64'h1);
    pc_reset = 1'b0; int_req = 2'b00;
    step("pcr_rel");

    // seq_reset overlay
    seq_reset = 1'b1;
    step("sr1");
    chk("sr1.seq_reset_out", 64'(seq_reset_out), 64'h3);
    chk("sr1.seq_en", 64'(seq_en), 64'h1);
    step("sr2");
    step("sr3");
    seq_reset = 1'b0;
    step("sr_drop");
    chk("sr_drop.seq_reset_out", 64'(seq_reset_out), 64'h2);

    // asynchronous reset in the middle of a drain window
    int_req = 2'b01;
    step("ar_k");
    step("ar_k1");
    interrupt_reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    int_req = 2'b00;
    interrupt_reset = 1'b0;

    // random phase
    for (int i = 0; i < 600; i++) begin
      int_req   = N'($urandom_range(0, 3));
      unit_pc   = {$urandom, $urandom};
      pc_reset  = ($urandom_range(0, 9) == 0);
      seq_reset = ($urandom_range(0, 7) == 0);
      step("rnd");
      if ($urandom_range(0, 149) == 0) begin
        interrupt_reset = 1'b1;
        #2;
        check_reset_values("rnd_rst");
        model_reset();
        interrupt_reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
